// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM states
// and a helper that maps funct3 onto an access size.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unlisted funct3 codes fall through to word size.
  function automatic size_e f3_size(input logic [2:0] f3);
    size_e s;
    s = SZ_W;
    unique case (1'b1)
      (f3 == F3_LB),
      (f3 == F3_LBU): s = SZ_B;
      (f3 == F3_LH),
      (f3 == F3_LHU): s = SZ_H;
      default:        s = SZ_W;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus.
// master = MEM stage (drives req/we/addr/be/wdata), slave = memory (ack/rdata).
interface mem_stage_if #(
  parameter int ADDR_W = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load extraction: picks byte/half out of the read word by address offset
// and sign- or zero-extends it. Ports: rdata_i, off_i, funct3_i -> data_o.
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rdata_i[{off_i, 3'b000} +: 8];
    h      = off_i[1] ? rdata_i[31:16]
                      : rdata_i[15:0];
    data_o = rdata_i;
    unique case (1'b1)
      (funct3_i == F3_LB):
        data_o = {{24{b[7]}}, b};
      (funct3_i == F3_LBU):
        data_o = {24'd0, b};
      (funct3_i == F3_LH):
        data_o = {{16{h[15]}}, h};
      (funct3_i == F3_LHU):
        data_o = {16'd0, h};
      default:
        data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: data-memory bus master, store lane steering, load
// extraction and the MEM/WB register; stalls upstream while an access waits.
// Ports: clk, reset (async, active-high); EX/MEM controls and data in;
// dmem (mem_stage_if.master); mem_stall; MEM/WB outputs, misalign_out,
// bus_err_out. Optional: define MEM_TIMEOUT_EN for the ack watchdog.
module mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       rs2_data_in,
  input  logic [4:0]        rd_in,
  mem_stage_if.master       dmem,
  output logic              mem_stall,
  output logic              reg_write_out,
  output logic [4:0]        rd_out,
  output logic [31:0]       wb_data_out,
  output logic              misalign_out,
  output logic              bus_err_out
);

  logic        access;
  logic        misal;
  logic        go;
  size_e       sz;
  logic [1:0]  off;
  logic [31:0] addr_w;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;

  mem_state_e  state_q;
  mem_state_e  state_d;
  logic        req;
  logic        tmo;

  logic        reg_write_q;
  logic [4:0]  rd_q;
  logic [31:0] wb_q;
  logic        misalign_q;

  assign access = mem_read_in | mem_write_in;
  assign sz     = f3_size(funct3_in);
  assign off    = alu_result_in[1:0];
  assign addr_w = {alu_result_in[31:2], 2'b00};

  // Only real memory accesses can be misaligned; ALU results pass through.
  assign misal = access
               & (((sz == SZ_H) & off[0])
               | ((sz == SZ_W) & (off != 2'b00)));
  assign go    = access & ~misal;

  always_comb begin
    be    = 4'b1111;
    wdata = rs2_data_in;
    if (mem_write_in) begin
      unique case (sz)
        SZ_B: begin
          be    = 4'b0001 << off;
          wdata = {4{rs2_data_in[7:0]}};
        end
        SZ_H: begin
          be    = off[1] ? 4'b1100 : 4'b0011;
          wdata = {2{rs2_data_in[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = rs2_data_in;
        end
      endcase
    end
  end

  load_align u_load_align (
    .rdata_i  (dmem.dmem_rdata),
    .off_i    (off),
    .funct3_i (funct3_in),
    .data_o   (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          bus_err_q;
`endif

  // Request is gated by reset so the bus drops the moment reset rises.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    tmo     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            req = 1'b1;
            if (!dmem.dmem_ack) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          req = 1'b1;
          if (dmem.dmem_ack) begin
            state_d = S_IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            req     = 1'b0;
            tmo     = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

`ifdef MEM_TIMEOUT_EN
  // Held at zero in IDLE, so it is clear on every entry to WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) cnt_d = '0;
    else                   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= tmo;
    end
  end

  assign bus_err_out = bus_err_q;
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES != 0) | tmo;
  assign bus_err_out = 1'b0;
`endif

  assign mem_stall       = req & ~dmem.dmem_ack;
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & mem_write_in;
  assign dmem.dmem_addr  = addr_w[ADDR_W-1:0];
  assign dmem.dmem_be    = be;
  assign dmem.dmem_wdata = wdata;

  // Stall or watchdog expiry inserts a bubble; rd/data hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_q        <= '0;
      misalign_q  <= 1'b0;
    end else if (mem_stall || tmo) begin
      reg_write_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      reg_write_q <= reg_write_in & ~misal;
      rd_q        <= rd_in;
      wb_q        <= mem_to_reg_in ? load_data
                                   : alu_result_in;
      misalign_q  <= misal;
    end
  end

  assign reg_write_out = reg_write_q;
  assign rd_out        = rd_q;
  assign wb_data_out   = wb_q;
  assign misalign_out  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus
// wait-state and reset-in-WAIT sequences with a result scoreboard.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_in, mem_to_reg_in;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, rs2_data_in;
  logic [4:0]  rd_in;
  logic        mem_stall, reg_write_out;
  logic [4:0]  rd_out;
  logic [31:0] wb_data_out;
  logic        misalign_out, bus_err_out;

  mem_stage_if #(.ADDR_W(32)) bus ();

  mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_write_in  (reg_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .funct3_in     (funct3_in),
    .alu_result_in (alu_result_in),
    .rs2_data_in   (rs2_data_in),
    .rd_in         (rd_in),
    .dmem          (bus),
    .mem_stall     (mem_stall),
    .reg_write_out (reg_write_out),
    .rd_out        (rd_out),
    .wb_data_out   (wb_data_out),
    .misalign_out  (misalign_out),
    .bus_err_out   (bus_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, m2r, rd_en, wr_en;
    logic [2:0]  f3;
    logic [31:0] alu, rs2, rdata;
    logic [4:0]  rd;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_rw;
    logic [31:0] e_wb;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        mis;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];
  exp_t e;
  int   tests  = 0;
  int   failed = 0;
  logic [4:0]  last_rd;
  logic [31:0] last_wb;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r,
                       input logic rd_en, input logic wr_en,
                       input logic [2:0] f3,
                       input logic [31:0] alu,
                       input logic [31:0] rs2,
                       input logic [4:0] rd);
    reg_write_in  = rw;
    mem_to_reg_in = m2r;
    mem_read_in   = rd_en;
    mem_write_in  = wr_en;
    funct3_in     = f3;
    alu_result_in = alu;
    rs2_data_in   = rs2;
    rd_in         = rd;
  endtask

  task automatic check_wb(input string name);
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".rw"},  32'(reg_write_out), 32'(e.rw));
      chk({name, ".rd"},  32'(rd_out),        32'(e.rd));
      chk({name, ".wb"},  wb_data_out,        e.wb);
      chk({name, ".mis"}, 32'(misalign_out),  32'(e.mis));
      last_rd = e.rd;
      last_wb = e.wb;
    end
  endtask

  initial begin
    // rw m2r rd wr f3 alu rs2 rdata rd | req we be wdata rw wb mis
    vecs[0]  = '{1,1,1,0,3'b010,32'h100,0,32'hDEADBEEF,5'd1,
                 1,0,4'hF,0,1,32'hDEADBEEF,0};
    vecs[1]  = '{1,1,1,0,3'b100,32'h101,0,32'h12345678,5'd2,
                 1,0,4'hF,0,1,32'h00000056,0};
    vecs[2]  = '{1,1,1,0,3'b001,32'h102,0,32'h80001234,5'd3,
                 1,0,4'hF,0,1,32'hFFFF8000,0};
    vecs[3]  = '{1,1,1,0,3'b101,32'h102,0,32'h80001234,5'd4,
                 1,0,4'hF,0,1,32'h00008000,0};
    vecs[4]  = '{1,1,1,0,3'b000,32'h103,0,32'h80FF0000,5'd5,
                 1,0,4'hF,0,1,32'hFFFFFF80,0};
    vecs[5]  = '{0,0,0,1,3'b000,32'h201,32'hAB,0,5'd0,
                 1,1,4'b0010,32'hABABABAB,0,32'h201,0};
    vecs[6]  = '{0,0,0,1,3'b001,32'h102,32'h1234,0,5'd0,
                 1,1,4'b1100,32'h12341234,0,32'h102,0};
    vecs[7]  = '{0,0,0,1,3'b010,32'h204,32'hCAFEF00D,0,5'd0,
                 1,1,4'hF,32'hCAFEF00D,0,32'h204,0};
    vecs[8]  = '{0,0,0,1,3'b000,32'h203,32'h5A,0,5'd0,
                 1,1,4'b1000,32'h5A5A5A5A,0,32'h203,0};
    vecs[9]  = '{1,1,1,0,3'b010,32'h101,0,0,5'd6,
                 0,0,4'hF,0,0,32'h0,1};
    vecs[10] = '{1,1,1,0,3'b001,32'h103,0,0,5'd8,
                 0,0,4'hF,0,0,32'h0,1};
    vecs[11] = '{1,1,1,0,3'b011,32'h102,0,0,5'd9,
                 0,0,4'hF,0,0,32'h0,1};
    vecs[12] = '{0,0,0,1,3'b001,32'h201,32'h77,0,5'd0,
                 0,0,4'hF,0,0,32'h201,1};
    vecs[13] = '{0,0,1,1,3'b010,32'h208,32'h11223344,0,5'd0,
                 1,1,4'hF,32'h11223344,0,32'h208,0};
    vecs[14] = '{1,0,0,0,3'b001,32'h13579BDF,0,0,5'd7,
                 0,0,4'hF,0,1,32'h13579BDF,0};

    reset = 1'b1;
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    #2;
    chk("rst.req",   32'(bus.dmem_req),   0);
    chk("rst.stall", 32'(mem_stall),      0);
    chk("rst.rw",    32'(reg_write_out),  0);
    chk("rst.rd",    32'(rd_out),         0);
    chk("rst.wb",    wb_data_out,         0);
    chk("rst.mis",   32'(misalign_out),   0);
    chk("rst.berr",  32'(bus_err_out),    0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Zero-wait table: ack held high (also ignored when no request).
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rw, vecs[i].m2r, vecs[i].rd_en,
            vecs[i].wr_en, vecs[i].f3, vecs[i].alu,
            vecs[i].rs2, vecs[i].rd);
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = vecs[i].rdata;
      #3;
      chk($sformatf("v%0d.req", i),
          32'(bus.dmem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d.we", i),
          32'(bus.dmem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d.stall", i), 32'(mem_stall), 0);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d.addr", i), bus.dmem_addr,
            {vecs[i].alu[31:2], 2'b00});
        chk($sformatf("v%0d.be", i),
            32'(bus.dmem_be), 32'(vecs[i].e_be));
        if (vecs[i].e_we)
          chk($sformatf("v%0d.wdata", i),
              bus.dmem_wdata, vecs[i].e_wdata);
      end
      sb.push_back('{vecs[i].e_rw, vecs[i].rd,
                     vecs[i].e_wb, vecs[i].e_mis});
      @(posedge clk); #1;
      check_wb($sformatf("v%0d", i));
    end

    // lb at 0x103, ack three cycles after the request.
    drive(1, 1, 1, 0, 3'b000, 32'h103, 0, 5'd10);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    sb.push_back('{1, 5'd10, 32'hFFFFFF80, 0});
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("ws%0d.stall", k), 32'(mem_stall), 1);
      chk($sformatf("ws%0d.req", k), 32'(bus.dmem_req), 1);
      chk($sformatf("ws%0d.addr", k), bus.dmem_addr, 32'h100);
      @(posedge clk); #1;
      chk($sformatf("ws%0d.bub_rw", k), 32'(reg_write_out), 0);
      chk($sformatf("ws%0d.bub_rd", k), 32'(rd_out), 32'(last_rd));
      chk($sformatf("ws%0d.bub_wb", k), wb_data_out, last_wb);
    end
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h80FF0000;
    #3;
    chk("ws.ack_stall", 32'(mem_stall), 0);
    chk("ws.ack_req",   32'(bus.dmem_req), 1);
    @(posedge clk); #1;
    check_wb("ws.done");
    bus.dmem_ack = 1'b0;

    // Reset asserted in WAIT, followed by a stray ack.
    drive(1, 1, 1, 0, 3'b010, 32'h300, 0, 5'd11);
    @(posedge clk); #1;
    #1;
    chk("rw.in_wait", 32'(mem_stall), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rw.req",   32'(bus.dmem_req),  0);
    chk("rw.we",    32'(bus.dmem_we),   0);
    chk("rw.stall", 32'(mem_stall),     0);
    chk("rw.rw",    32'(reg_write_out), 0);
    chk("rw.rd",    32'(rd_out),        0);
    chk("rw.wb",    wb_data_out,        0);
    chk("rw.mis",   32'(misalign_out),  0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hFFFFFFFF;
    #3;
    chk("rw.stray_req",   32'(bus.dmem_req), 0);
    chk("rw.stray_stall", 32'(mem_stall),    0);
    @(posedge clk); #1;
    chk("rw.post_rw", 32'(reg_write_out), 0);
    chk("rw.post_wb", wb_data_out,        0);
    bus.dmem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      drive(1, 1, 1, 0, 3'b010, 32'h400, 0, 5'd12);
      for (int c = 0; c < 40; c++) begin
        #3;
        if (!mem_stall) break;
        n++;
        @(posedge clk); #1;
      end
      chk("to.stall_cycles", n, 16);
      chk("to.req_dropped", 32'(bus.dmem_req), 0);
      @(posedge clk); #1;
      chk("to.berr", 32'(bus_err_out), 1);
      chk("to.rw",   32'(reg_write_out), 0);
      drive(0, 0, 0, 0, 3'b000, 0, 0, 0);
      @(posedge clk); #1;
      chk("to.berr_pulse", 32'(bus_err_out), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline.
- Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Drives the data-memory request/acknowledge bus and performs byte/halfword store lane steering and load extraction with sign extension.
- Registers the result into the MEM/WB boundary; while a memory access is outstanding it stalls the upstream stages.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- TIMEOUT_CYCLES, 16, watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in  in  1 each  control from EX/MEM
- funct3_in  in  3  access size/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
- alu_result_in  in  32  effective address or ALU result
- rs2_data_in  in  32  store data
- rd_in  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  ADDR_W  word-aligned address {alu_result_in[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  drive EX/MEM enable = !mem_stall and stall IF/ID/EX
- reg_write_out  out  1  MEM/WB control
- rd_out  out  5  MEM/WB destination register
- wb_data_out  out  32  MEM/WB write-back data
- misalign_out  out  1  registered misaligned-access flag
- bus_err_out  out  1  registered timeout flag (tied 0 without the feature)

Behaviour:
- Access = mem_read_in | mem_write_in.
  - Both set: treated as a write; the read is ignored.
- Misaligned:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - funct3 codes outside the list above are treated as word.
- FSM states: IDLE, WAIT.
  - IDLE with an aligned access: dmem_req=1 combinationally.
    - dmem_ack=1 in the same cycle: zero-wait completion, stay IDLE.
    - Otherwise: go to WAIT.
  - WAIT: dmem_req held at 1 with the address, write data and byte enables unchanged (inputs are held by the stall). On dmem_ack go to IDLE.
- mem_stall = dmem_req & !dmem_ack.
- dmem_ack while dmem_req=0 is ignored.
- Store steering:
  - sb: be = 1<<addr[1:0]; wdata = byte replicated into all 4 lanes.
  - sh: be = addr[1] ? 1100 : 0011; wdata = half replicated.
  - sw: be = 1111.
  - Reads drive be = 1111 and dmem_we = 0.
- Load extraction: select byte/half from dmem_rdata by addr[1:0].
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
- MEM/WB register, updated every cycle:
  - If mem_stall: bubble; reg_write_out<=0, misalign_out<=0, rd_out and wb_data_out hold.
  - Else:
    - reg_write_out <= reg_write_in & !misaligned.
    - rd_out <= rd_in.
    - wb_data_out <= mem_to_reg_in ? load data : alu_result_in.
    - misalign_out <= misaligned & access.
- Misaligned access:
  - No bus request and no stall.
  - Register write is suppressed and misalign_out pulses for one cycle.
- Latency: one cycle through the stage plus N cycles when ack arrives N cycles after the request.
- Reset (at any time, including mid-WAIT):
  - State goes to IDLE.
  - All registered outputs go to 0.
  - dmem_req, dmem_we and mem_stall deassert immediately.
  - An ack arriving after reset is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and counts each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without ack: drop the request, return to IDLE, deassert the stall.
  - Register a bubble with bus_err_out=1 for one cycle.
- Undefined: no counter; bus_err_out is constant 0 and WAIT waits indefinitely.

Decomposition:
- Package riscv_mem_pkg:
  - funct3 constants F3_LB/LH/LW/LBU/LHU.
  - FSM state encoding.
- Sub-module load_align: combinational extraction and sign extension from rdata, addr[1:0] and funct3.

Test Plan:
- lw at 0x100, ack in the same cycle, rdata=0xDEADBEEF -> no stall; next cycle reg_write_out=1, wb_data_out=0xDEADBEEF.
- lb at 0x103, ack after 3 cycles, rdata=0x80FF_0000 -> mem_stall high for 3 cycles with bubbles on MEM/WB; then wb_data_out=0xFFFFFF80.
- sh at 0x102, rs2=0x0000_1234 -> dmem_we=1, be=1100, wdata=0x12341234; reg_write_out=0.
- lw at 0x101 -> dmem_req never asserts, misalign_out=1 for one cycle, reg_write_out=0.
- reset asserted during WAIT, then a stray ack -> dmem_req drops immediately, all outputs 0, ack ignored.
- With MEM_TIMEOUT_EN, no ack for 16 cycles -> request dropped, stall released, bus_err_out=1 for one cycle.
